// File: rtl/raabb_pkg.sv
// Shared types, FloPoCo field layout and helpers for the ray/AABB batch tester.
package raabb_pkg;

    localparam int unsigned WE_DEF        = 11;
    localparam int unsigned WF_DEF        = 52;
    localparam int unsigned LAT_DEF       = 30;
    localparam int unsigned MAX_BOXES_DEF = 16;
    localparam int unsigned CNTW_DEF      = 16;

    function automatic int unsigned fp_w(input int unsigned we, input int unsigned wf);
        return we + wf + 3;
    endfunction

    localparam int unsigned CORE_WE = 11;
    localparam int unsigned CORE_WF = 52;
    localparam int unsigned CORE_W  = fp_w(CORE_WE, CORE_WF);

    // FloPoCo word layout: {exc[1:0], sign, exp, frac}
    localparam int unsigned FRAC_LSB = 0;
    localparam int unsigned EXP_LSB  = CORE_WF;
    localparam int unsigned SIGN_BIT = CORE_WF + CORE_WE;
    localparam int unsigned EXC_LSB  = SIGN_BIT + 1;

    // Ordered-key width: magnitude plus one guard bit, then a sign
    localparam int unsigned MW = CORE_WE + CORE_WF + 1;
    localparam int unsigned KW = MW + 1;

    typedef logic [CORE_W-1:0] fp_t;
    typedef logic signed [KW-1:0] key_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic [3*CORE_W-1:0] pack3(input fp_t x, input fp_t y, input fp_t z);
        return {z, y, x};
    endfunction

    function automatic fp_t unpack3(input logic [3*CORE_W-1:0] v, input int unsigned axis);
        return v[axis*CORE_W +: CORE_W];
    endfunction

    // Monotone signed key: zero -> 0, normals strictly ordered, inf/NaN saturate.
    function automatic key_t fp_key(input fp_t v);
        logic [MW-1:0] mag;
        case (v[EXC_LSB+1:EXC_LSB])
            2'b00:   mag = '0;
            2'b01:   mag = {1'b0, v[SIGN_BIT-1:EXP_LSB], v[EXP_LSB-1:FRAC_LSB]} + MW'(1);
            default: mag = '1;
        endcase
        return v[SIGN_BIT] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

endpackage

// File: rtl/Ray_AABB_11_52.sv
// Fixed-latency interval ray/AABB slab test on FloPoCo 11/52 words (no stall, no reset).
module Ray_AABB_11_52
    import raabb_pkg::*;
#(
    parameter int unsigned LAT = 30
) (
    input  logic                  clk,
    input  logic [3*CORE_W-1:0]   o_up,
    input  logic [3*CORE_W-1:0]   o_low,
    input  logic [2:0]            dir_sgn,
    input  logic [3*CORE_W-1:0]   rdiv_up,
    input  logic [3*CORE_W-1:0]   rdiv_low,
    input  logic [3*CORE_W-1:0]   box_lo,
    input  logic [3*CORE_W-1:0]   box_hi,
    output logic                  hit_miss
);
    localparam key_t KEY_MIN = {1'b1, {(KW-1){1'b0}}};
    localparam key_t KEY_MAX = {1'b0, {(KW-1){1'b1}}};

    logic           hit_c;
    key_t           near, far, org, near_max, far_min;
    logic [LAT-1:0] pipe;

    // Negative axes are mirrored so every slab is entered at its low face
    always_comb begin
        hit_c    = 1'b1;
        near     = '0;
        far      = '0;
        org      = '0;
        near_max = KEY_MIN;
        far_min  = KEY_MAX;
        for (int unsigned a = 0; a < 3; a++) begin
            if (dir_sgn[a]) begin
                near = -fp_key(unpack3(box_hi, a));
                far  = -fp_key(unpack3(box_lo, a));
                org  = -fp_key(unpack3(o_up, a));
            end else begin
                near = fp_key(unpack3(box_lo, a));
                far  = fp_key(unpack3(box_hi, a));
                org  = fp_key(unpack3(o_low, a));
            end
            if (far < org) hit_c = 1'b0;
            if (fp_key(unpack3(rdiv_up, a)) < fp_key(unpack3(rdiv_low, a))) hit_c = 1'b0;
            if (near > near_max) near_max = near;
            if (far < far_min) far_min = far;
        end
        if (near_max > far_min) hit_c = 1'b0;
    end

    always_ff @(posedge clk) begin
        pipe[0] <= hit_c;
        for (int i = 1; i < int'(LAT); i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign hit_miss = pipe[LAT-1];

endmodule

// File: rtl/raabb_tag_pipe.sv
// Fixed-depth tag shift register with valid bits, synchronous clear and in-flight count.
module raabb_tag_pipe #(
    parameter int unsigned DEPTH = 31,
    parameter int unsigned TAGW  = 16
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic [TAGW-1:0]            in_tag,
    output logic                       out_valid,
    output logic [TAGW-1:0]            out_tag,
    output logic [$clog2(DEPTH+1)-1:0] inflight
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] vld;
    logic [TAGW-1:0]  tag [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            vld      <= '0;
            inflight <= '0;
        end else begin
            vld[0] <= in_valid;
            for (int i = 1; i < int'(DEPTH); i++) begin
                vld[i] <= vld[i-1];
            end
            case ({in_valid, vld[DEPTH-1]})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Tag payload needs no clear: it is qualified by vld
    always_ff @(posedge clk) begin
        tag[0] <= in_tag;
        for (int i = 1; i < int'(DEPTH); i++) begin
            tag[i] <= tag[i-1];
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_tag   = tag[DEPTH-1];

endmodule

// File: rtl/raabb_batch_tester.sv
// Streams AABBs for one latched ray through the slab-test core and folds results into one record.
module raabb_batch_tester
    import raabb_pkg::*;
#(
    parameter  int unsigned WE        = WE_DEF,
    parameter  int unsigned WF        = WF_DEF,
    parameter  int unsigned LAT       = LAT_DEF,
    parameter  int unsigned MAX_BOXES = MAX_BOXES_DEF,
    parameter  int unsigned CNTW      = CNTW_DEF,
    localparam int unsigned W         = fp_w(WE, WF)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ray_valid,
    output logic                 ray_ready,
    input  logic [3*W-1:0]       ray_o_up,
    input  logic [3*W-1:0]       ray_o_low,
    input  logic [2:0]           ray_dir_sgn,
    input  logic [3*W-1:0]       ray_rdiv_up,
    input  logic [3*W-1:0]       ray_rdiv_low,
    input  logic                 box_valid,
    output logic                 box_ready,
    input  logic [3*W-1:0]       box_lo,
    input  logic [3*W-1:0]       box_hi,
    input  logic                 box_last,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [MAX_BOXES-1:0] res_mask,
    output logic [CNTW-1:0]      res_count,
    output logic [CNTW-1:0]      res_first,
    output logic                 res_any,
    output logic                 res_overflow
);
    localparam int unsigned IFW = $clog2(LAT + 2);
    localparam int unsigned MIW = (MAX_BOXES > 1) ? $clog2(MAX_BOXES) : 1;

    if (W != CORE_W) begin : g_width_check
        $error("raabb_batch_tester: W=%0d does not match core width %0d", W, CORE_W);
    end

    state_t state, state_next;

    logic [3*W-1:0] lat_o_up, lat_o_low, lat_rdiv_up, lat_rdiv_low;
    logic [2:0]     lat_dir_sgn;
    logic [3*W-1:0] c_o_up, c_o_low, c_rdiv_up, c_rdiv_low, c_box_lo, c_box_hi;
    logic [2:0]     c_dir_sgn;
    logic [CNTW-1:0] idx;

    logic            ret_valid;
    logic [CNTW-1:0] ret_tag;
    logic [IFW-1:0]  inflight;
    logic            core_hit;

    logic ray_acc, box_acc;
    assign ray_acc = ray_valid && ray_ready;
    assign box_acc = box_valid && box_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // DRAIN exits on the edge that retires the last tag
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (ray_acc) state_next = ST_STREAM;
            ST_STREAM: if (box_acc && box_last) state_next = ST_DRAIN;
            ST_DRAIN:  if (inflight == '0 || (inflight == IFW'(1) && ret_valid)) state_next = ST_DONE;
            ST_DONE:   if (res_valid && res_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ray_ready    <= 1'b1;
            box_ready    <= 1'b0;
            res_valid    <= 1'b0;
            res_mask     <= '0;
            res_count    <= '0;
            res_first    <= '0;
            res_any      <= 1'b0;
            res_overflow <= 1'b0;
            idx          <= '0;
        end else begin
            ray_ready <= (state_next == ST_IDLE);
            box_ready <= (state_next == ST_STREAM);
            res_valid <= (state_next == ST_DONE);
            if (ray_acc) begin
                res_mask     <= '0;
                res_count    <= '0;
                res_first    <= '0;
                res_any      <= 1'b0;
                res_overflow <= 1'b0;
                idx          <= '0;
            end
            if (box_acc) begin
                if (32'(idx) >= MAX_BOXES) res_overflow <= 1'b1;
                if (idx != '1) idx <= idx + CNTW'(1);
            end
            if (ret_valid && core_hit) begin
                if (32'(ret_tag) < MAX_BOXES) res_mask[ret_tag[MIW-1:0]] <= 1'b1;
                if (res_count != '1) res_count <= res_count + CNTW'(1);
                if (!res_any) res_first <= ret_tag;
                res_any <= 1'b1;
            end
        end
    end

    // Ray latch and core input registers carry no reset; results are gated by tag valids
    always_ff @(posedge clk) begin
        if (ray_acc) begin
            lat_o_up     <= ray_o_up;
            lat_o_low    <= ray_o_low;
            lat_dir_sgn  <= ray_dir_sgn;
            lat_rdiv_up  <= ray_rdiv_up;
            lat_rdiv_low <= ray_rdiv_low;
        end
        if (box_acc) begin
            c_o_up     <= lat_o_up;
            c_o_low    <= lat_o_low;
            c_dir_sgn  <= lat_dir_sgn;
            c_rdiv_up  <= lat_rdiv_up;
            c_rdiv_low <= lat_rdiv_low;
            c_box_lo   <= box_lo;
            c_box_hi   <= box_hi;
        end
    end

    Ray_AABB_11_52 #(
        .LAT(LAT)
    ) u_core (
        .clk      (clk),
        .o_up     (c_o_up),
        .o_low    (c_o_low),
        .dir_sgn  (c_dir_sgn),
        .rdiv_up  (c_rdiv_up),
        .rdiv_low (c_rdiv_low),
        .box_lo   (c_box_lo),
        .box_hi   (c_box_hi),
        .hit_miss (core_hit)
    );

    raabb_tag_pipe #(
        .DEPTH(LAT + 1),
        .TAGW (CNTW)
    ) u_tags (
        .clk      (clk),
        .clr      (rst),
        .in_valid (box_acc),
        .in_tag   (idx),
        .out_valid(ret_valid),
        .out_tag  (ret_tag),
        .inflight (inflight)
    );

endmodule

// File: tb/tb_raabb_batch_tester.sv
// Directed and randomized checks of raabb_batch_tester against a real-arithmetic slab model.
module tb_raabb_batch_tester;
    import raabb_pkg::*;

    localparam int unsigned W    = 66;
    localparam int unsigned LAT  = 30;
    localparam int unsigned MB   = 16;
    localparam int unsigned CNTW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            ray_valid, ray_ready;
    logic [3*W-1:0]  ray_o_up, ray_o_low, ray_rdiv_up, ray_rdiv_low;
    logic [2:0]      ray_dir_sgn;
    logic            box_valid, box_ready, box_last;
    logic [3*W-1:0]  box_lo, box_hi;
    logic            res_valid, res_ready;
    logic [MB-1:0]   res_mask;
    logic [CNTW-1:0] res_count, res_first;
    logic            res_any, res_overflow;

    raabb_batch_tester dut (
        .clk(clk), .rst(rst),
        .ray_valid(ray_valid), .ray_ready(ray_ready),
        .ray_o_up(ray_o_up), .ray_o_low(ray_o_low), .ray_dir_sgn(ray_dir_sgn),
        .ray_rdiv_up(ray_rdiv_up), .ray_rdiv_low(ray_rdiv_low),
        .box_valid(box_valid), .box_ready(box_ready),
        .box_lo(box_lo), .box_hi(box_hi), .box_last(box_last),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_mask(res_mask), .res_count(res_count), .res_first(res_first),
        .res_any(res_any), .res_overflow(res_overflow)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    real         blo [0:31][0:2];
    real         bhi [0:31][0:2];
    real         rd  [0:2];
    logic [2:0]  dsg;
    int          gap [0:31];
    int unsigned t_last;

    logic [MB-1:0]   e_mask;
    logic [CNTW-1:0] e_count, e_first;
    logic            e_any, e_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] fp(input real v);
        if (v == 0.0) return '0;
        return {2'b01, $realtobits(v)};
    endfunction

    function automatic logic [3*W-1:0] junk();
        logic [3*W-1:0] j;
        for (int i = 0; i < 3*int'(W); i++) j[i] = 1'($urandom);
        return j;
    endfunction

    task automatic set_cube(input int k, input real a, input real b);
        for (int ax = 0; ax < 3; ax++) begin
            blo[k][ax] = a;
            bhi[k][ax] = b;
        end
    endtask

    task automatic set_exp(input logic [MB-1:0] m, input int c, input int f, input logic a, input logic o);
        e_mask = m; e_count = CNTW'(c); e_first = CNTW'(f); e_any = a; e_ovf = o;
    endtask

    // Slab test in real arithmetic with origin at 0
    function automatic logic model_hit(input int k);
        real tn, tf, t1, t2;
        tn = -1.0e300;
        tf = 1.0e300;
        for (int ax = 0; ax < 3; ax++) begin
            t1 = blo[k][ax] * rd[ax];
            t2 = bhi[k][ax] * rd[ax];
            tn = (t1 < t2) ? ((t1 > tn) ? t1 : tn) : ((t2 > tn) ? t2 : tn);
            tf = (t1 > t2) ? ((t1 < tf) ? t1 : tf) : ((t2 < tf) ? t2 : tf);
        end
        return (tn <= tf) && (tf >= 0.0);
    endfunction

    task automatic model_record(input int n);
        set_exp('0, 0, 0, 1'b0, n > int'(MB));
        for (int k = 0; k < n; k++) begin
            if (model_hit(k)) begin
                if (k < int'(MB)) e_mask[k] = 1'b1;
                if (!e_any) e_first = CNTW'(k);
                e_count = e_count + 1'b1;
                e_any = 1'b1;
            end
        end
    endtask

    task automatic send_ray();
        int n = 0;
        ray_valid    = 1'b1;
        ray_o_up     = '0;
        ray_o_low    = '0;
        ray_dir_sgn  = dsg;
        ray_rdiv_up  = pack3(fp(rd[0]), fp(rd[1]), fp(rd[2]));
        ray_rdiv_low = ray_rdiv_up;
        while (!ray_ready && n < 100) begin @(negedge clk); n++; end
        chk("ray_handshake", 64'(ray_ready), 64'(1));
        @(negedge clk);
        ray_valid = 1'b0;
    endtask

    task automatic send_boxes(input int n);
        int w;
        for (int k = 0; k < n; k++) begin
            box_valid = 1'b0;
            for (int g = 0; g < gap[k]; g++) begin
                box_lo = junk(); box_hi = junk(); box_last = 1'($urandom);
                @(negedge clk);
            end
            box_valid = 1'b1;
            box_lo    = pack3(fp(blo[k][0]), fp(blo[k][1]), fp(blo[k][2]));
            box_hi    = pack3(fp(bhi[k][0]), fp(bhi[k][1]), fp(bhi[k][2]));
            box_last  = (k == n - 1);
            w = 0;
            while (!box_ready && w < 100) begin @(negedge clk); w++; end
            if (!box_ready) chk("box_handshake", 64'(box_ready), 64'(1));
            t_last = cyc;
            @(negedge clk);
        end
        box_valid = 1'b0;
        box_last  = 1'b0;
    endtask

    task automatic wait_res(output int unsigned c);
        int n = 0;
        while (!res_valid && n < int'(LAT) + 200) begin @(negedge clk); n++; end
        chk("res_valid_wait", 64'(res_valid), 64'(1));
        c = cyc;
    endtask

    task automatic check_rec(input string tag);
        chk({tag, ".mask"},  64'(res_mask),     64'(e_mask));
        chk({tag, ".count"}, 64'(res_count),    64'(e_count));
        chk({tag, ".first"}, 64'(res_first),    64'(e_first));
        chk({tag, ".any"},   64'(res_any),      64'(e_any));
        chk({tag, ".ovf"},   64'(res_overflow), 64'(e_ovf));
    endtask

    task automatic take_res(input string tag);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, ".idle_ray_ready"}, 64'(ray_ready), 64'(1));
        chk({tag, ".idle_res_valid"}, 64'(res_valid), 64'(0));
    endtask

    task automatic default_ray();
        dsg = 3'b000;
        for (int ax = 0; ax < 3; ax++) rd[ax] = 1.0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c_res;
        int n, seen;
        rst = 1'b1; ray_valid = 1'b0; box_valid = 1'b0; box_last = 1'b0; res_ready = 1'b0;
        ray_o_up = '0; ray_o_low = '0; ray_rdiv_up = '0; ray_rdiv_low = '0; ray_dir_sgn = '0;
        box_lo = '0; box_hi = '0;
        for (int k = 0; k < 32; k++) gap[k] = 0;
        default_ray();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Test 1: reset held 3 cycles mid-STREAM
        send_ray();
        box_valid = 1'b1; box_lo = junk(); box_hi = junk();
        repeat (2) @(negedge clk);
        rst = 1'b1; box_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t1.ray_ready", 64'(ray_ready), 64'(1));
        chk("t1.box_ready", 64'(box_ready), 64'(0));
        chk("t1.res_valid", 64'(res_valid), 64'(0));
        set_exp('0, 0, 0, 1'b0, 1'b0);
        check_rec("t1");

        // Test 2: hit / miss / hit back-to-back
        set_cube(0, 1.0, 2.0); set_cube(1, -2.0, -1.0); set_cube(2, 3.0, 4.0);
        send_ray();
        send_boxes(3);
        wait_res(c_res);
        chk("t2.latency", 64'(c_res), 64'(t_last + LAT + 2));
        set_exp(16'h0005, 2, 0, 1'b1, 1'b0);
        check_rec("t2");
        take_res("t2");

        // Test 3: gaps of 1, 3, 0 and a result held for 5 cycles
        gap[0] = 1; gap[1] = 3; gap[2] = 0;
        send_ray();
        send_boxes(3);
        gap[0] = 0; gap[1] = 0;
        wait_res(c_res);
        for (int i = 0; i < 5; i++) begin
            chk("t3.hold_valid", 64'(res_valid), 64'(1));
            check_rec("t3");
            @(negedge clk);
        end
        take_res("t3");

        // Test 4: 18 boxes overflow the mask
        for (int k = 0; k < 18; k++) set_cube(k, 1.0, 2.0);
        send_ray();
        send_boxes(18);
        wait_res(c_res);
        set_exp(16'hFFFF, 18, 0, 1'b1, 1'b1);
        check_rec("t4");
        take_res("t4");

        // Test 5: single miss
        set_cube(0, -2.0, -1.0);
        send_ray();
        send_boxes(1);
        wait_res(c_res);
        set_exp('0, 0, 0, 1'b0, 1'b0);
        check_rec("t5");
        take_res("t5");

        // Test 6: reset 2 cycles into DRAIN aborts the ray
        set_cube(0, 1.0, 2.0); set_cube(1, 1.0, 2.0); set_cube(2, 1.0, 2.0);
        send_ray();
        send_boxes(3);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < int'(LAT) + 10; i++) begin
            if (res_valid) seen++;
            @(negedge clk);
        end
        chk("t6.no_aborted_record", 64'(seen), 64'(0));
        chk("t6.ray_ready", 64'(ray_ready), 64'(1));
        set_cube(0, 1.0, 2.0);
        send_ray();
        send_boxes(1);
        wait_res(c_res);
        set_exp(16'h0001, 1, 0, 1'b1, 1'b0);
        check_rec("t6");
        take_res("t6");

        // Randomized rays against the slab model
        for (int r = 0; r < 8; r++) begin
            real a, b;
            dsg = 3'($urandom);
            for (int ax = 0; ax < 3; ax++) rd[ax] = dsg[ax] ? -1.0 : 1.0;
            n = int'($urandom_range(20, 1));
            for (int k = 0; k < n; k++) begin
                gap[k] = int'($urandom_range(2, 0));
                for (int ax = 0; ax < 3; ax++) begin
                    a = real'(int'($urandom_range(8, 0)) - 4);
                    b = real'(int'($urandom_range(8, 0)) - 4);
                    blo[k][ax] = (a < b) ? a : b;
                    bhi[k][ax] = (a < b) ? b : a;
                end
            end
            model_record(n);
            send_ray();
            send_boxes(n);
            wait_res(c_res);
            chk("rnd.latency", 64'(c_res), 64'(t_last + LAT + 2));
            check_rec("rnd");
            repeat ($urandom_range(3, 0)) @(negedge clk);
            take_res("rnd");
        end
        for (int k = 0; k < 32; k++) gap[k] = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
